simple_cpu_top: RTL and testbench
=================================

Name: simple_cpu_top

Overview:
- Minimal 16-bit command-driven datapath: a small data memory, two operand registers (A, B), a combinational ALU, and a registered result with status flags.
- An external sequencer/bench issues one 16-bit command per clock, plus a data word and a memory address.
- This is the top level of the simple CPU. It has no program counter or fetch: every cycle's command comes from the ports.

Parameters:
- DATA_W, 16, datapath and memory word width.
- MEM_DEPTH, 16, number of memory words (power of two).
- ADDR_W, 4, log2(MEM_DEPTH); only address[ADDR_W-1:0] is used.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- command  in  16  [15:12] opcode, [3:0] sub-op; bits [11:4] ignored.
- number  in  16  immediate data for store/immediate-load commands.
- address  in  16  memory address; upper bits above ADDR_W ignored (wrap).
- result  out  16  registered result register.
- cout  out  1  registered carry flag.
- overflow  out  1  registered signed-overflow flag.
- NO  out  1  registered negative flag, equal to result[15] of the last ALU op.
- ZO  out  1  registered zero flag, set when the last ALU result == 0.

Behaviour:
- Reset (rst=1 at a rising edge): clears A, B, result, cout, overflow, NO, ZO and every memory word to 0. Reset has priority over any command.
- One command is decoded per cycle. Its effect is visible on the outputs after that rising edge (1-cycle latency). Command fields are sampled only at the edge.
- Opcode 0x0: NOP; all state holds.
- Opcode 0x1: immediate load. Sub-op 0 sets A = number; sub-op 1 sets B = number; other sub-ops act as NOP.
- Opcode 0x2: store immediate, mem[address] = number.
- Opcode 0x3: memory load, reading mem[address]. Sub-op 0 loads into A; sub-op 1 loads into B; sub-op 2 loads into result. Other sub-ops act as NOP.
- A load into result leaves the flags unchanged.
- Memory read is combinational within the cycle, so a load returns the value written by any earlier cycle. A store followed by a load of the same address on the next cycle returns the new value.
- Opcode 0x4: ALU operation. result <= f(A, B) and all four flags update. Sub-ops:
  - 0 ADD: A+B; cout = carry out of bit 15; overflow = signed overflow.
  - 1 SUB: A-B computed as A+~B+1; cout = that carry (1 means no borrow); overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise; cout = 0, overflow = 0.
  - 5 NOT: ~A; cout = 0, overflow = 0.
  - 6 SHL: A<<1; cout = A[15]; overflow = 0.
  - 7 SHR (logical): A>>1; cout = A[0]; overflow = 0.
  - Sub-ops 8-15 act as NOP; no flag change.
- For every valid ALU sub-op: NO = new result[15]; ZO = (new result == 0).
- Opcode 0x5: store result, mem[address] = result (current registered value).
- Opcodes 0x6-0xF: NOP.
- Arithmetic wraps modulo 2^16. No exceptions or stall; the block is always ready.
- Address wrap: address 0x0011 with MEM_DEPTH 16 accesses word 1.

Decomposition:
- Shared package simple_cpu_pkg holds:
  - opcode constants: OP_NOP, OP_LDI, OP_ST, OP_LD, OP_ALU, OP_STR;
  - load-target sub-op constants: LD_A, LD_B, LD_R;
  - ALU op enum: ADD, SUB, AND, OR, XOR, NOT, SHL, SHR;
  - DATA_W default.
- One sub-module, simple_cpu_alu: purely combinational. Inputs A, B, op; outputs y, carry, ovf. The top handles decode, registers, memory and flag registration.

Test Plan:
- Reset then idle: rst=1 for 1 cycle -> result=0x0000, cout=overflow=NO=ZO=0; load of any address returns 0.
- Add chain:
  - store 8 @0 (0x2000) and 4 @1;
  - load A @0 (0x3000), load B @1 (0x3001), add (0x4000) -> result=0x000C, ZO=0, NO=0, cout=0;
  - store result @2 (0x5000), load result @2 (0x3002) -> result=0x000C.
- Overflow/carry:
  - A=0x7FFF, B=0x0001, ADD -> result=0x8000, overflow=1, NO=1, cout=0;
  - A=0xFFFF, B=0x0001, ADD -> result=0x0000, cout=1, ZO=1, overflow=0.
- SUB: A=5, B=5 -> result=0, ZO=1, cout=1; A=3, B=5 -> result=0xFFFE, NO=1, cout=0.
- Logic/shift: A=0x8001, SHL -> result=0x0002, cout=1; SHR -> result=0x4000, cout=1; A=0xF0F0, B=0x0FF0, AND -> result=0x00F0.
- Sync reset mid-sequence: assert rst in the same cycle as a store command -> store suppressed, all state 0. Address 0x0011 aliases word 1. Opcode 0x9 -> no state change.

Source files
------------

// File: rtl/simple_cpu_pkg.sv
// Shared constants and types for the command-driven simple CPU datapath.
package simple_cpu_pkg;

    localparam int DATA_W = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_ST  = 4'h2;
    localparam logic [3:0] OP_LD  = 4'h3;
    localparam logic [3:0] OP_ALU = 4'h4;
    localparam logic [3:0] OP_STR = 4'h5;

    localparam logic [3:0] LD_A = 4'h0;
    localparam logic [3:0] LD_B = 4'h1;
    localparam logic [3:0] LD_R = 4'h2;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        AND = 4'd2,
        OR  = 4'd3,
        XOR = 4'd4,
        NOT = 4'd5,
        SHL = 4'd6,
        SHR = 4'd7
    } alu_op_e;

endpackage

// File: rtl/simple_cpu_alu.sv
// Combinational ALU: result, carry-out and signed-overflow for one operation.
module simple_cpu_alu
    import simple_cpu_pkg::*;
#(
    parameter int DATA_W = simple_cpu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] y,
    output logic              carry,
    output logic              ovf
);

    logic [DATA_W-1:0] b_eff;
    logic              cin;
    logic [DATA_W:0]   sum;

    // SUB reuses the adder as a + ~b + 1 so carry means "no borrow".
    always_comb begin
        b_eff = (op == SUB) ? ~b : b;
        cin   = (op == SUB);
        sum   = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin};
    end

    always_comb begin
        y     = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            ADD, SUB: begin
                y     = sum[DATA_W-1:0];
                carry = sum[DATA_W];
                ovf   = (a[DATA_W-1] == b_eff[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
            end
            AND: y = a & b;
            OR:  y = a | b;
            XOR: y = a ^ b;
            NOT: y = ~a;
            SHL: begin
                y     = {a[DATA_W-2:0], 1'b0};
                carry = a[DATA_W-1];
            end
            SHR: begin
                y     = {1'b0, a[DATA_W-1:1]};
                carry = a[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/simple_cpu_top.sv
// Simple CPU top: decodes one port-driven command per clock into operand
// registers, a small data memory and a flagged result register.
module simple_cpu_top
    import simple_cpu_pkg::*;
#(
    parameter int DATA_W    = simple_cpu_pkg::DATA_W,
    parameter int MEM_DEPTH = 16,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       command,
    input  logic [DATA_W-1:0] number,
    input  logic [15:0]       address,
    output logic [DATA_W-1:0] result,
    output logic              cout,
    output logic              overflow,
    output logic              NO,
    output logic              ZO
);

    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [3:0]        opcode;
    logic [3:0]        sub_op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W-1:0] alu_y;
    logic              alu_carry;
    logic              alu_ovf;
    logic              unused_bits;

    assign opcode      = command[15:12];
    assign sub_op      = command[3:0];
    assign addr        = address[ADDR_W-1:0];
    assign mem_rd      = mem[addr];
    assign unused_bits = ^{command[11:4], address[15:ADDR_W]};

    simple_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .a     (reg_a),
        .b     (reg_b),
        .op    (sub_op),
        .y     (alu_y),
        .carry (alu_carry),
        .ovf   (alu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            reg_a    <= '0;
            reg_b    <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            NO       <= 1'b0;
            ZO       <= 1'b0;
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
        end else begin
            case (opcode)
                OP_LDI: begin
                    if (sub_op == LD_A) reg_a <= number;
                    else if (sub_op == LD_B) reg_b <= number;
                end
                OP_ST: mem[addr] <= number;
                OP_LD: begin
                    // Loading into result deliberately leaves the flags alone.
                    if (sub_op == LD_A) reg_a <= mem_rd;
                    else if (sub_op == LD_B) reg_b <= mem_rd;
                    else if (sub_op == LD_R) result <= mem_rd;
                end
                OP_ALU: begin
                    if (!sub_op[3]) begin
                        result   <= alu_y;
                        cout     <= alu_carry;
                        overflow <= alu_ovf;
                        NO       <= alu_y[DATA_W-1];
                        ZO       <= (alu_y == '0);
                    end
                end
                OP_STR: mem[addr] <= result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_cpu_top.sv
// Directed self-checking bench for simple_cpu_top with hand-computed results.
module tb_simple_cpu_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] command = '0;
    logic [15:0] number = '0;
    logic [15:0] address = '0;
    logic [15:0] result;
    logic        cout;
    logic        overflow;
    logic        NO;
    logic        ZO;

    int total = 0;
    int bad   = 0;

    simple_cpu_top dut (
        .clk      (clk),
        .rst      (rst),
        .command  (command),
        .number   (number),
        .address  (address),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .NO       (NO),
        .ZO       (ZO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%04h want 0x%04h", tag, obs, exp);
        end
    endtask

    // Drive one command, let the rising edge take it, sample 1 time unit later.
    task automatic issue(input logic [15:0] c, input logic [15:0] n, input logic [15:0] a);
        command = c;
        number  = n;
        address = a;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] flags();
        return {12'h000, cout, overflow, NO, ZO};
    endfunction

    initial begin
        rst = 1'b1;
        issue(16'h2000, 16'h1234, 16'h0003);
        rst = 1'b0;
        chk("rst_result", result, 16'h0000);
        chk("rst_flags", flags(), 16'h0000);
        issue(16'h3002, 16'h0000, 16'h0003);
        chk("rst_mem3", result, 16'h0000);

        // Add chain through memory.
        issue(16'h2000, 16'h0008, 16'h0000);
        issue(16'h2000, 16'h0004, 16'h0001);
        issue(16'h3000, 16'h0000, 16'h0000);
        issue(16'h3001, 16'h0000, 16'h0001);
        issue(16'h4000, 16'h0000, 16'h0000);
        chk("add_result", result, 16'h000C);
        chk("add_flags", flags(), 16'h0000);
        issue(16'h5000, 16'h0000, 16'h0002);
        issue(16'h3002, 16'h0000, 16'h0000);
        chk("ldr_mem0", result, 16'h0008);
        issue(16'h3002, 16'h0000, 16'h0002);
        chk("ldr_mem2", result, 16'h000C);

        // Signed overflow, then a result load must keep the flags.
        issue(16'h1000, 16'h7FFF, 16'h0000);
        issue(16'h1001, 16'h0001, 16'h0000);
        issue(16'h4000, 16'h0000, 16'h0000);
        chk("ovf_result", result, 16'h8000);
        chk("ovf_flags", flags(), 16'h0006);
        issue(16'h3002, 16'h0000, 16'h0000);
        chk("ldr_keep_result", result, 16'h0008);
        chk("ldr_keep_flags", flags(), 16'h0006);

        // Unsigned carry wrapping to zero.
        issue(16'h1000, 16'hFFFF, 16'h0000);
        issue(16'h4000, 16'h0000, 16'h0000);
        chk("carry_result", result, 16'h0000);
        chk("carry_flags", flags(), 16'h0009);

        // SUB: equal operands and borrow.
        issue(16'h1000, 16'h0005, 16'h0000);
        issue(16'h1001, 16'h0005, 16'h0000);
        issue(16'h4001, 16'h0000, 16'h0000);
        chk("sub_eq_result", result, 16'h0000);
        chk("sub_eq_flags", flags(), 16'h0009);
        issue(16'h1000, 16'h0003, 16'h0000);
        issue(16'h4001, 16'h0000, 16'h0000);
        chk("sub_neg_result", result, 16'hFFFE);
        chk("sub_neg_flags", flags(), 16'h0002);

        // Shifts and logic.
        issue(16'h1000, 16'h8001, 16'h0000);
        issue(16'h4006, 16'h0000, 16'h0000);
        chk("shl_result", result, 16'h0002);
        chk("shl_flags", flags(), 16'h0008);
        issue(16'h4007, 16'h0000, 16'h0000);
        chk("shr_result", result, 16'h4000);
        chk("shr_flags", flags(), 16'h0008);
        issue(16'h1000, 16'hF0F0, 16'h0000);
        issue(16'h1001, 16'h0FF0, 16'h0000);
        issue(16'h4002, 16'h0000, 16'h0000);
        chk("and_result", result, 16'h00F0);
        chk("and_flags", flags(), 16'h0000);
        issue(16'h4003, 16'h0000, 16'h0000);
        chk("or_result", result, 16'hFFF0);
        chk("or_flags", flags(), 16'h0002);
        issue(16'h4004, 16'h0000, 16'h0000);
        chk("xor_result", result, 16'hFF00);
        issue(16'h4005, 16'h0000, 16'h0000);
        chk("not_result", result, 16'h0F0F);
        chk("not_flags", flags(), 16'h0000);

        // Invalid ALU sub-op, high opcode and invalid load target are all NOPs.
        issue(16'h4008, 16'h0000, 16'h0000);
        chk("alu_nop_result", result, 16'h0F0F);
        issue(16'h9000, 16'h5555, 16'h0000);
        chk("op9_result", result, 16'h0F0F);
        chk("op9_flags", flags(), 16'h0000);
        issue(16'h1002, 16'h1234, 16'h0000);
        issue(16'h4000, 16'h0000, 16'h0000);
        chk("ldi_nop_add", result, 16'h00E0);
        chk("ldi_nop_flags", flags(), 16'h0008);

        // Address wrap: 0x0011 lands on word 1.
        issue(16'h2000, 16'hBEEF, 16'h0011);
        issue(16'h3002, 16'h0000, 16'h0001);
        chk("wrap_mem1", result, 16'hBEEF);

        // Reset concurrent with a store wins and clears everything.
        rst = 1'b1;
        issue(16'h2000, 16'h5555, 16'h0003);
        rst = 1'b0;
        chk("rst2_result", result, 16'h0000);
        chk("rst2_flags", flags(), 16'h0000);
        issue(16'h3002, 16'h0000, 16'h0003);
        chk("rst2_mem3", result, 16'h0000);
        issue(16'h3002, 16'h0000, 16'h0001);
        chk("rst2_mem1", result, 16'h0000);
        issue(16'h4000, 16'h0000, 16'h0000);
        chk("rst2_ab_add", result, 16'h0000);
        chk("rst2_ab_flags", flags(), 16'h0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
